// File: rtl/down_counter_timer.sv
// Loadable down counter with terminal-count pulse, one-shot or auto-reload.
// Every output comes straight from a flop clocked by sysclk.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Next-state: load beats counting; terminal count reloads or parks in DONE.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Hold; enable is ignored until a nonzero load.
                end
                S_RUN: begin
                    if (enable) begin
                        if (count_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = S_DONE;
                            end
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                S_DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tc_pulse = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed vector table,
// hand-written corner sequences and random stimulus against a reference model.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         sysclk = 1'b0;
    logic         reset, load, enable, auto_reload;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         busy, done, tc_pulse;

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 sysclk = ~sysclk;

    down_counter_timer #(.WIDTH(W)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .tc_pulse    (tc_pulse)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: remaining count, reload value, running/finished flags.
    int m_cnt = 0, m_rel = 0;
    bit m_run = 0, m_fin = 0, m_tc = 0;

    typedef struct {
        logic         rst, ld;
        logic [W-1:0] lv;
        logic         en, ar;
        logic [W-1:0] c;
        logic         b, d, t;
    } vec_t;

    vec_t tbl[$];

    function automatic void model_edge(input bit r, l, input int lv, input bit e, a);
        m_tc = 0;
        if (r) begin
            m_cnt = 0; m_rel = 0; m_run = 0; m_fin = 0;
        end else if (l) begin
            m_cnt = lv; m_rel = lv; m_run = (lv != 0); m_fin = 0;
        end else if (m_run && e) begin
            if (m_cnt == 1) begin
                m_tc = 1;
                if (a) m_cnt = m_rel;
                else begin
                    m_cnt = 0; m_run = 0; m_fin = 1;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endfunction

    // Apply one cycle of inputs, step the model, sample #1 after the edge.
    task automatic drive(input bit r, l, input logic [W-1:0] lv, input bit e, a);
        reset = r; load = l; load_val = lv; enable = e; auto_reload = a;
        @(posedge sysclk);
        model_edge(r, l, int'(lv), e, a);
        #1;
    endtask

    // Compare {count,busy,done,tc_pulse} against expectation.
    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got count=%0d busy=%0d done=%0d tc=%0d, expected count=%0d busy=%0d done=%0d tc=%0d",
                     name, got >> 3, (got >> 2) & 1, (got >> 1) & 1, got & 1,
                     exp >> 3, (exp >> 2) & 1, (exp >> 1) & 1, exp & 1);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int outs();
        return int'({count, busy, done, tc_pulse});
    endfunction

    initial begin
        int n;
        reset = 1'b1; load = 1'b0; load_val = '0; enable = 1'b0; auto_reload = 1'b0;

        //                rst ld lv en ar   c  b  d  t
        // reset with enable high
        tbl.push_back('{1, 0, 0, 1, 0,   0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0,   0, 0, 0, 0});
        // one-shot from 5
        tbl.push_back('{0, 1, 5, 0, 0,   5, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   4, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   3, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   2, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   0, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 1, 1,   0, 0, 1, 0});
        // pause
        tbl.push_back('{0, 1, 4, 0, 0,   4, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   3, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0,   3, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0,   3, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   2, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   0, 0, 1, 1});
        // auto-reload from 3
        tbl.push_back('{0, 1, 3, 0, 1,   3, 1, 0, 0});
        for (int i = 0; i < 3; i++) begin
            tbl.push_back('{0, 0, 0, 1, 1,   2, 1, 0, 0});
            tbl.push_back('{0, 0, 0, 1, 1,   1, 1, 0, 0});
            tbl.push_back('{0, 0, 0, 1, 1,   3, 1, 0, 1});
        end
        // load coinciding with terminal count
        tbl.push_back('{0, 0, 0, 1, 1,   2, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1,   1, 1, 0, 0});
        tbl.push_back('{0, 1, 7, 1, 1,   7, 1, 0, 0});
        // load of zero goes idle
        tbl.push_back('{0, 1, 0, 1, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   0, 0, 0, 0});
        // reload value 1: tc held continuously
        tbl.push_back('{0, 1, 1, 0, 1,   1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1,   1, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 1,   1, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1,   1, 1, 0, 0});
        // auto_reload only matters at the terminal edge
        tbl.push_back('{0, 1, 2, 0, 0,   2, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1,   1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   0, 0, 1, 1});
        // reset mid-count
        tbl.push_back('{0, 1, 9, 0, 0,   9, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   8, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   7, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   6, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1,   0, 0, 0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].ar);
            check($sformatf("vec%0d", i), outs(),
                  int'({tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].t}));
        end

        // Full-range countdown: 15 enabled cycles to the terminal pulse.
        drive(0, 1, 15, 0, 0);
        check("load15", outs(), int'({4'd15, 1'b1, 1'b0, 1'b0}));
        n = 0;
        while (n < 20) begin
            drive(0, 0, 0, 1, 0);
            n++;
            if (tc_pulse) break;
        end
        check_int("cycles_to_tc15", n, 15);
        check("tc15_state", outs(), int'({4'd0, 1'b0, 1'b1, 1'b1}));

        // DONE holds for 10 cycles whatever enable/auto_reload do.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, i[0], 1);
            check($sformatf("done_hold%0d", i), outs(), int'({4'd0, 1'b0, 1'b1, 1'b0}));
        end

        // Random stimulus against the reference model.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, l, e, a;
            logic [W-1:0] lv;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 14) == 0);
            lv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            e  = ($urandom_range(0, 9) < 7);
            a  = ($urandom_range(0, 2) != 0);
            drive(r, l, lv, e, a);
            check("rand", outs(),
                  int'({W'(m_cnt), m_run, m_fin, m_tc}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Synchronous, loadable down counter with terminal-count detection, for countdown timing in the same designs that use the up counter. A start value is loaded and decremented on each enabled sysclk edge. A one-cycle terminal-count pulse fires when the count reaches zero. The counter then either stops in DONE or auto-reloads and repeats. All outputs are registered on one clock, so the block drops into LED/timer designs without ripple-clock skew.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.

Ports:
sysclk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset; sampled on the sysclk rising edge.
load  input  1  load strobe; captures load_val into the counter and the reload register.
load_val  input  WIDTH  start value for the countdown.
enable  input  1  count enable; 1 = decrement this cycle, 0 = hold (pause).
auto_reload  input  1  1 = reload from the reload register on terminal count and keep running.
count  output  WIDTH  current counter value (registered).
busy  output  1  1 while in RUN.
done  output  1  1 while in DONE (level).
tc_pulse  output  1  single-cycle pulse, registered, asserted the cycle after terminal count.

Behaviour:
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- Reset: dominates every other input on the same edge.
  - state=IDLE, count=0, reload register=0.
  - busy=0, done=0, tc_pulse=0.
- Priority each edge: reset > load > enable/decrement > hold.
- Load, accepted in any state:
  - Sets count<=load_val and reload register<=load_val.
  - If load_val!=0: state<=RUN. If load_val==0: state<=IDLE, and no tc_pulse is generated.
  - tc_pulse is 0 on the cycle following a load.
- IDLE: count holds; enable has no effect.
- RUN with enable=0: count holds and state stays RUN.
- RUN with enable=1 and count>1: count<=count-1.
- Terminal count (RUN, enable=1, count==1):
  - tc_pulse<=1 for exactly one cycle.
  - auto_reload=1: count<=reload register, state stays RUN.
  - auto_reload=0: count<=0, state<=DONE.
- DONE: count holds 0; done stays 1 until the next load or reset. enable and auto_reload are ignored.
- Load coinciding with terminal count: the load wins and no tc_pulse is issued.
- tc_pulse deasserts on the next edge unless a back-to-back terminal count occurs. That is only possible with auto_reload and reload value 1, where tc_pulse is held high continuously.
- auto_reload is sampled only at the terminal-count edge; changing it mid-count has no other effect.
- Arithmetic: unsigned modulo 2^WIDTH. count never underflows, because decrement is only performed for count>=1.
- Latency:
  - load -> count valid on the next edge.
  - Terminal count -> tc_pulse on the same edge on which count becomes 0 or the reload value.
- Reset mid-countdown: aborts immediately to IDLE, count=0, no tc_pulse.

Test Plan:
- Reset behaviour: reset=1 for 2 cycles with enable=1, load=0 -> count=0, busy=0, done=0, tc_pulse=0 on every cycle.
- One-shot countdown: load_val=5, load 1 cycle, then enable=1, auto_reload=0 -> count 5,4,3,2,1,0 on successive edges; tc_pulse=1 only on the cycle count becomes 0; done=1 and busy=0 thereafter; count stays 0 for 10 further cycles.
- Pause: load_val=4, enable toggled 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0; exactly one tc_pulse.
- Auto-reload: load_val=3, auto_reload=1, enable=1 for 9 cycles -> count 3,2,1,3,2,1,3,2,1,3; tc_pulse on cycles 3, 6 and 9; done never 1.
- Edge cases:
  - Load coinciding with terminal count, load_val=7 -> count=7, tc_pulse=0.
  - load_val=0 -> state IDLE, count=0, no tc_pulse.
  - WIDTH=4, load_val=15 -> 15 enabled cycles to tc_pulse.
- Reset mid-count: load_val=9, enable=1 for 3 cycles, then reset=1 -> next edge count=0, busy=0, done=0; no tc_pulse before the next load.
